// File: rtl/lcd_char_writer_pkg.sv
// Shared constants for the HD44780 character writer: controller commands,
// top-level FSM state encoding and small command helpers.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_FUNC_SET  = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_ROW1_BASE     = 8'h40;

  localparam int INIT_LEN = 6;

  typedef logic [2:0] state_t;
  localparam state_t ST_PWR_WAIT  = 3'd0;
  localparam state_t ST_INIT      = 3'd1;
  localparam state_t ST_INIT_WAIT = 3'd2;
  localparam state_t ST_IDLE      = 3'd3;
  localparam state_t ST_ADDR      = 3'd4;
  localparam state_t ST_DATA      = 3'd5;
  localparam state_t ST_DATA_WAIT = 3'd6;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return LCD_CMD_FUNC_SET;
      3'd3:             return LCD_CMD_DISP_ON;
      3'd4:             return LCD_CMD_CLEAR;
      default:          return LCD_CMD_ENTRY;
    endcase
  endfunction

  function automatic logic [7:0] ddram_addr(input logic row, input logic [3:0] col);
    return LCD_CMD_SET_DDRAM | (row ? LCD_ROW1_BASE : 8'h00) | {4'h0, col};
  endfunction

endpackage

// File: rtl/lcd_char_writer_if.sv
// Character request channel into the LCD writer (valid/ready handshake).
interface lcd_char_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_row;
  logic [3:0] char_col;
  logic       char_ready;

  modport master (output char_valid, char_data, char_row, char_col, input char_ready);
  modport slave  (input char_valid, char_data, char_row, char_col, output char_ready);
endinterface

// File: rtl/lcd_char_writer_bus_cycle.sv
// One LCD bus write: SETUP, EN_HIGH_CYC cycles of lcd_en, then a settle wait.
// A new start is taken in the last wait cycle so writes can run back to back.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int EN_HIGH_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_is_data,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_lcd_rs,
  output logic       o_lcd_en,
  output logic [7:0] o_lcd_data
);

  localparam int CW = $clog2(EN_HIGH_CYC + CMD_WAIT_CYC + CLEAR_WAIT_CYC + 1);
  localparam logic [CW-1:0] EN_LOAD  = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] CMD_LOAD = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_WAIT_CYC - 1);

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_SETUP = 2'd1;
  localparam logic [1:0] PH_EN    = 2'd2;
  localparam logic [1:0] PH_WAIT  = 2'd3;

  logic [1:0]    r_phase;
  logic [CW-1:0] r_cnt;
  logic          r_long;
  logic          r_rs;
  logic          r_en;
  logic [7:0]    r_data;
  logic          w_accept;

  assign o_busy     = (r_phase != PH_IDLE);
  assign o_done     = (r_phase == PH_WAIT) && (r_cnt == '0);
  assign w_accept   = i_start && (!o_busy || o_done);
  assign o_lcd_rs   = r_rs;
  assign o_lcd_en   = r_en;
  assign o_lcd_data = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_long  <= 1'b0;
      r_rs    <= 1'b0;
      r_en    <= 1'b0;
      r_data  <= 8'h00;
    end else if (w_accept) begin
      r_phase <= PH_SETUP;
      r_rs    <= i_is_data;
      r_data  <= i_byte;
      r_en    <= 1'b0;
      r_long  <= !i_is_data && (i_byte == LCD_CMD_CLEAR);
    end else begin
      case (r_phase)
        PH_SETUP: begin
          r_phase <= PH_EN;
          r_en    <= 1'b1;
          r_cnt   <= EN_LOAD;
        end
        PH_EN: begin
          if (r_cnt == '0) begin
            r_phase <= PH_WAIT;
            r_en    <= 1'b0;
            r_cnt   <= r_long ? CLR_LOAD : CMD_LOAD;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        PH_WAIT: begin
          if (r_cnt == '0) r_phase <= PH_IDLE;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_char_writer.sv
// HD44780 16x2 character writer: power-up wait, init commands, then one
// set-DDRAM-address + data write pair per accepted character.
//   state      | meaning
//   PWR_WAIT   | power-up delay before any bus activity
//   INIT       | launch first init command
//   INIT_WAIT  | init writes in flight, next one chained on done
//   IDLE       | char_ready high, waiting for a request
//   ADDR       | launch address command for captured position
//   DATA       | address write in flight, data write chained on done
//   DATA_WAIT  | data write in flight
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int EN_HIGH_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000,
  parameter int POWERUP_CYC    = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  lcd_char_if.slave  io_char,
  output logic       o_init_done,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic [7:0] o_lcd_data
);

  localparam int PW = $clog2(POWERUP_CYC + 1);
  localparam logic [PW-1:0] PWR_LOAD = PW'(POWERUP_CYC - 1);
  localparam logic [2:0]    LAST_IDX = 3'(INIT_LEN - 1);

  state_t        r_state;
  logic [PW-1:0] r_pwr_cnt;
  logic [2:0]    r_idx;
  logic          r_ready;
  logic          r_init_done;
  logic [7:0]    r_char;
  logic          r_row;
  logic [3:0]    r_col;

  logic          w_start;
  logic          w_is_data;
  logic [7:0]    w_byte;
  logic          w_busy;
  logic          w_done;
  logic          w_accept;

  assign w_accept           = r_ready && io_char.char_valid;
  assign io_char.char_ready = r_ready;
  assign o_init_done        = r_init_done;
  assign o_lcd_rw           = 1'b0;

  always_comb begin
    w_start   = 1'b0;
    w_is_data = 1'b0;
    w_byte    = 8'h00;
    case (r_state)
      ST_INIT: begin
        w_start = !w_busy;
        w_byte  = init_cmd(r_idx);
      end
      ST_INIT_WAIT: begin
        w_start = w_done && (r_idx != LAST_IDX);
        w_byte  = init_cmd(r_idx + 3'd1);
      end
      ST_ADDR: begin
        w_start = !w_busy;
        w_byte  = ddram_addr(r_row, r_col);
      end
      ST_DATA: begin
        w_start   = w_done;
        w_is_data = 1'b1;
        w_byte    = r_char;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_PWR_WAIT;
      r_pwr_cnt   <= PWR_LOAD;
      r_idx       <= 3'd0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_char      <= 8'h00;
      r_row       <= 1'b0;
      r_col       <= 4'h0;
    end else begin
      case (r_state)
        ST_PWR_WAIT: begin
          if (r_pwr_cnt == '0) begin
            r_state <= ST_INIT;
            r_idx   <= 3'd0;
          end else begin
            r_pwr_cnt <= r_pwr_cnt - PW'(1);
          end
        end
        ST_INIT: if (w_start) r_state <= ST_INIT_WAIT;
        ST_INIT_WAIT: begin
          if (w_done) begin
            if (r_idx == LAST_IDX) begin
              r_state     <= ST_IDLE;
              r_ready     <= 1'b1;
              r_init_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            r_char  <= io_char.char_data;
            r_row   <= io_char.char_row;
            r_col   <= io_char.char_col;
            r_ready <= 1'b0;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: if (w_start) r_state <= ST_DATA;
        ST_DATA: if (w_done) r_state <= ST_DATA_WAIT;
        ST_DATA_WAIT: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= ST_PWR_WAIT;
      endcase
    end
  end

  lcd_bus_cycle #(
    .EN_HIGH_CYC   (EN_HIGH_CYC),
    .CMD_WAIT_CYC  (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
  ) u_bus (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_is_data (w_is_data),
    .i_byte    (w_byte),
    .o_busy    (w_busy),
    .o_done    (w_done),
    .o_lcd_rs  (o_lcd_rs),
    .o_lcd_en  (o_lcd_en),
    .o_lcd_data(o_lcd_data)
  );

endmodule

// File: tb/tb_lcd_char_writer.sv
// Bench for lcd_char_writer: init sequence checked write by write, then a
// cycle-level transfer model compared against the bus every cycle.
module tb_lcd_char_writer;

  localparam int EN   = 2;
  localparam int CMDW = 4;
  localparam int CLRW = 8;
  localparam int PWR  = 10;
  localparam int LEN  = 1 + EN + CMDW;
  localparam int BACK = 2 * LEN + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_char_if u_if ();
  logic       init_done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  lcd_char_writer #(
    .EN_HIGH_CYC(EN), .CMD_WAIT_CYC(CMDW), .CLEAR_WAIT_CYC(CLRW), .POWERUP_CYC(PWR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_char(u_if), .o_init_done(init_done),
    .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en), .o_lcd_data(lcd_data)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // stimulus driver: 0 = directed values, 1 = random, 2 = valid held with random fields
  int         mode = 1;
  logic       d_valid = 1'b0;
  logic [7:0] d_data = 8'h00;
  logic       d_row = 1'b0;
  logic [3:0] d_col = 4'h0;

  initial begin
    u_if.char_valid = 1'b0;
    u_if.char_data  = 8'h00;
    u_if.char_row   = 1'b0;
    u_if.char_col   = 4'h0;
    forever begin
      @(negedge clk);
      case (mode)
        1: begin
          u_if.char_valid = 1'($urandom);
          u_if.char_data  = 8'($urandom);
          u_if.char_row   = 1'($urandom);
          u_if.char_col   = 4'($urandom);
        end
        2: begin
          u_if.char_valid = 1'b1;
          u_if.char_data  = 8'($urandom);
          u_if.char_row   = 1'($urandom);
          u_if.char_col   = 4'($urandom);
        end
        default: begin
          u_if.char_valid = d_valid;
          u_if.char_data  = d_data;
          u_if.char_row   = d_row;
          u_if.char_col   = d_col;
        end
      endcase
    end
  end

  // transfer model: acceptance time plus captured character/address
  bit         m_arm = 1'b0;
  int         m_anchor = 0;
  bit         m_on = 1'b0;
  int         m_t_acc = 0;
  int         m_acc_cnt = 0;
  bit         m_have = 1'b0;
  bit         m_prev_rs = 1'b0;
  logic [7:0] m_chr = 8'h00;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_prev_data = 8'h06;

  always @(posedge clk) begin : model
    int t;
    bit hv;
    t  = m_on ? m_t_acc : m_anchor;
    hv = m_on ? m_have : 1'b0;
    if (!m_arm) begin
      m_on <= 1'b0;
    end else begin
      m_on <= 1'b1;
      if (!m_on) begin
        m_t_acc <= m_anchor;
        m_have  <= 1'b0;
      end
      if (rst_n && (cyc - t >= BACK) && u_if.char_valid) begin
        m_t_acc     <= cyc + 1;
        m_chr       <= u_if.char_data;
        m_addr      <= 8'(128 + 64 * int'(u_if.char_row) + int'(u_if.char_col));
        m_prev_rs   <= hv;
        m_prev_data <= hv ? m_chr : 8'h06;
        m_have      <= 1'b1;
        m_acc_cnt   <= m_acc_cnt + 1;
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin : compare
    int d, off;
    logic e_en, e_rs, e_rdy;
    logic [7:0] e_data;
    if (m_on) begin
      d = cyc - m_t_acc;
      if (d == 0) begin
        e_rdy = 1'b0; e_en = 1'b0; e_rs = m_prev_rs; e_data = m_prev_data;
      end else if (d < BACK) begin
        e_rdy  = 1'b0;
        e_rs   = (d > LEN);
        off    = (d > LEN) ? d - LEN - 1 : d - 1;
        e_en   = (off >= 1) && (off <= EN);
        e_data = (d > LEN) ? m_chr : m_addr;
      end else begin
        e_rdy = 1'b1; e_en = 1'b0; e_rs = m_have; e_data = m_have ? m_chr : 8'h06;
      end
      chk("cyc_lcd_en", lcd_en, e_en);
      chk("cyc_lcd_rs", lcd_rs, e_rs);
      chk("cyc_lcd_data", lcd_data, e_data);
      chk("cyc_char_ready", u_if.char_ready, e_rdy);
      chk("cyc_init_done", init_done, 1'b1);
      chk("cyc_lcd_rw", lcd_rw, 1'b0);
    end
  end

  task automatic run_init();
    logic [7:0] cmds [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int low, hi, prev_w;
    prev_w = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      low = 0;
      while (lcd_en == 1'b0 && low < 200) begin
        chk("init_ready_low", u_if.char_ready, 1'b0);
        chk("init_done_low", init_done, 1'b0);
        low++;
        @(negedge clk);
      end
      if (i == 0) chk("pwr_wait_min", low >= PWR, 1'b1);
      else        chk("init_gap", low, prev_w + 1);
      chk("init_rs", lcd_rs, 1'b0);
      chk("init_cmd", lcd_data, cmds[i]);
      hi = 0;
      while (lcd_en == 1'b1 && hi < 200) begin
        hi++;
        @(negedge clk);
      end
      chk("init_en_width", hi, EN);
      prev_w = (cmds[i] == 8'h01) ? CLRW : CMDW;
    end
    low = 0;
    while (init_done == 1'b0 && low < 200) begin
      chk("init_tail_en", lcd_en, 1'b0);
      chk("init_tail_ready", u_if.char_ready, 1'b0);
      low++;
      @(negedge clk);
    end
    chk("init_final_wait", low, prev_w);
    chk("init_ready_up", u_if.char_ready, 1'b1);
  endtask

  task automatic arm();
    m_anchor = cyc - BACK;
    m_arm    = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 1000 && cyc < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle();
    mode    = 0;
    d_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 100 && (cyc - m_t_acc < BACK + 1); i++) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] dt, input logic rw, input logic [3:0] cl, output int acc);
    int c0;
    wait_idle();
    c0 = m_acc_cnt;
    d_data = dt; d_row = rw; d_col = cl; d_valid = 1'b1;
    for (int i = 0; i < 40 && m_acc_cnt == c0; i++) @(negedge clk);
    chk("send_accepted", m_acc_cnt != c0, 1'b1);
    d_valid = 1'b0;
    acc = m_t_acc;
  endtask

  initial begin
    int a, a1, a2, c0;
    mode = 1;
    repeat (3) @(negedge clk);
    chk("rst_lcd_en", lcd_en, 1'b0);
    chk("rst_lcd_rs", lcd_rs, 1'b0);
    chk("rst_lcd_rw", lcd_rw, 1'b0);
    chk("rst_lcd_data", lcd_data, 8'h00);
    chk("rst_char_ready", u_if.char_ready, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    rst_n = 1'b1;
    run_init();
    arm();

    send(8'h37, 1'b0, 4'd5, a);
    chk("model_addr_r0c5", m_addr, 8'h85);
    wait_cyc(a + 1);
    chk("addr_setup_data", lcd_data, 8'h85);
    chk("addr_setup_en", lcd_en, 1'b0);
    wait_cyc(a + 2);
    chk("first_en_rise", lcd_en, 1'b1);
    wait_cyc(a + 9);
    chk("data_37", lcd_data, 8'h37);
    chk("data_37_rs", lcd_rs, 1'b1);
    wait_cyc(a + 14);
    chk("ready_still_low", u_if.char_ready, 1'b0);
    wait_cyc(a + 15);
    chk("ready_back_15", u_if.char_ready, 1'b1);

    send(8'h46, 1'b1, 4'd15, a);
    chk("model_addr_r1c15", m_addr, 8'hCF);
    wait_cyc(a + 1);
    chk("addr_cf", lcd_data, 8'hCF);
    wait_cyc(a + 8);
    chk("data_46", lcd_data, 8'h46);
    chk("data_46_rs", lcd_rs, 1'b1);

    wait_idle();
    c0 = m_acc_cnt;
    mode = 2;
    for (int i = 0; i < 60 && m_acc_cnt < c0 + 1; i++) @(negedge clk);
    a1 = m_t_acc;
    for (int i = 0; i < 60 && m_acc_cnt < c0 + 2; i++) @(negedge clk);
    a2 = m_t_acc;
    mode = 0;
    d_valid = 1'b0;
    chk("b2b_count", m_acc_cnt - c0, 2);
    chk("b2b_spacing", a2 - a1, BACK + 1);
    wait_idle();

    mode = 1;
    repeat (400) @(negedge clk);
    wait_idle();

    send(8'($urandom), 1'($urandom), 4'($urandom), a);
    wait_cyc(a + 9);
    chk("pre_reset_en", lcd_en, 1'b1);
    m_arm = 1'b0;
    mode = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_en", lcd_en, 1'b0);
    chk("async_rst_init_done", init_done, 1'b0);
    chk("async_rst_ready", u_if.char_ready, 1'b0);
    chk("async_rst_data", lcd_data, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_init();
    arm();
    repeat (200) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
